// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative multiply/divide unit with architectural HI/LO registers for the
//   pipelined MIPS core. A mult/multu/div/divu issued from Execute runs in the
//   background for WIDTH cycles of CALC plus one FIX cycle. Hi/Lo are
//   written only when a result is committed or by mthi/mtlo while idle.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   StartE    in   Execute holds a mult/multu/div/divu
//   OpE       in   00 mult, 01 multu, 10 div, 11 divu
//   SrcAE     in   rs operand (multiplicand / dividend / mthi-mtlo data)
//   SrcBE     in   rt operand (multiplier / divisor)
//   WriteHiE  in   mthi in Execute
//   WriteLoE  in   mtlo in Execute
//   UseHiLoD  in   Decode instruction touches HI/LO
//   Hi, Lo    out  architectural HI/LO registers
//   BusyE     out  calculation in progress
//   DoneE     out  one-cycle pulse in the FIX cycle
//   StallMD   out  stall request to the hazard unit
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic [1:0]       OpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             WriteHiE,
  input  logic             WriteLoE,
  input  logic             UseHiLoD,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             BusyE,
  output logic             DoneE,
  output logic             StallMD
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic             start;

  // Latched operation and operands
  logic             op_div;
  logic             op_signed;
  logic             sgn_a;
  logic             sgn_b;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  // Iteration state: acc is the product accumulator, aux holds the shifting
  // multiplier (mult) or the dividend shifting into quotient bits (div),
  // rem is the partial remainder.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   aux;
  logic [WIDTH:0]     rem;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_trial;
  logic               div_bit;
  logic [WIDTH:0]     div_rem_nxt;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return (~v) + (2*WIDTH)'(1);
  endfunction

  assign start = (state == IDLE) && StartE;

  // ---- control: state register and counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (start)
        cnt <= CW'(WIDTH);
      else if (state == CALC)
        cnt <= cnt - CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    BusyE     = 1'b0;
    DoneE     = 1'b0;
    case (state)
      IDLE: begin
        if (StartE)
          state_nxt = CALC;
      end
      CALC: begin
        BusyE = 1'b1;
        if (cnt == CW'(1))
          state_nxt = FIX;
      end
      FIX: begin
        BusyE     = 1'b1;
        DoneE     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign StallMD = BusyE & UseHiLoD;

  // ---- one iteration step
  always_comb begin
    mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (aux[0] ? {1'b0, opa} : '0);
    div_shift   = {rem[WIDTH-1:0], aux[WIDTH-1]};
    div_trial   = {1'b0, div_shift} - {2'b00, opb};
    div_bit     = ~div_trial[WIDTH+1];
    div_rem_nxt = div_bit ? div_trial[WIDTH:0] : div_shift;
  end

  // Operands are stored as magnitudes for signed ops so both algorithms run
  // unsigned; signs are reapplied in FIX.
  always_ff @(posedge clk) begin
    if (start) begin
      op_div    <= OpE[1];
      op_signed <= ~OpE[0];
      sgn_a     <= ~OpE[0] & SrcAE[WIDTH-1];
      sgn_b     <= ~OpE[0] & SrcBE[WIDTH-1];
      opa       <= (~OpE[0] & SrcAE[WIDTH-1]) ? neg_w(SrcAE) : SrcAE;
      opb       <= (~OpE[0] & SrcBE[WIDTH-1]) ? neg_w(SrcBE) : SrcBE;
      acc       <= '0;
      rem       <= '0;
      if (OpE[1])
        aux <= (~OpE[0] & SrcAE[WIDTH-1]) ? neg_w(SrcAE) : SrcAE;
      else
        aux <= (~OpE[0] & SrcBE[WIDTH-1]) ? neg_w(SrcBE) : SrcBE;
    end else if (state == CALC) begin
      if (op_div) begin
        rem <= div_rem_nxt;
        aux <= {aux[WIDTH-2:0], div_bit};
      end else begin
        acc <= {mul_sum, acc[WIDTH-1:1]};
        aux <= aux >> 1;
      end
    end
  end

  // ---- FIX: sign correction and special cases
  // min-negative / -1 needs no special case: |min| / 1 gives quotient
  // 2^(WIDTH-1), and negating it yields the same bit pattern, remainder 0.
  always_comb begin
    prod   = (op_signed && (sgn_a ^ sgn_b)) ? neg_2w(acc) : acc;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (op_div) begin
      if (opb == '0) begin
        // Divide by zero: all-ones quotient, dividend back as remainder.
        fix_lo = '1;
        fix_hi = sgn_a ? neg_w(opa) : opa;
      end else begin
        fix_lo = (op_signed && (sgn_a ^ sgn_b)) ? neg_w(aux) : aux;
        fix_hi = sgn_a ? neg_w(rem[WIDTH-1:0]) : rem[WIDTH-1:0];
      end
    end
  end

  // ---- architectural HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Hi <= '0;
      Lo <= '0;
    end else if (state == FIX) begin
      Hi <= fix_hi;
      Lo <= fix_lo;
    end else if (state == IDLE && !StartE) begin
      if (WriteHiE)
        Hi <= SrcAE;
      if (WriteLoE)
        Lo <= SrcAE;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         StartE;
  logic [1:0]   OpE;
  logic [W-1:0] SrcAE;
  logic [W-1:0] SrcBE;
  logic         WriteHiE;
  logic         WriteLoE;
  logic         UseHiLoD;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;
  logic         BusyE;
  logic         DoneE;
  logic         StallMD;

  int n_checks;
  int n_errors;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .StartE(StartE), .OpE(OpE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteHiE(WriteHiE), .WriteLoE(WriteLoE),
    .UseHiLoD(UseHiLoD), .Hi(Hi), .Lo(Lo), .BusyE(BusyE), .DoneE(DoneE),
    .StallMD(StallMD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: MIPS mult/multu/div/divu semantics from plain wide arithmetic.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] up;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    case (op)
      2'b00: begin sq = sa * sb; hi = sq[63:32]; lo = sq[31:0]; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; end
      default: begin
        if (b == 0) begin
          lo = '1;
          hi = a;
        end else if (op == 2'b10) begin
          sq = sa / sb;
          sr = sa % sb;
          lo = sq[31:0];
          hi = sr[31:0];
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  // Issue one operation, track BusyE/DoneE, confirm Hi/Lo hold during the
  // calculation and hold the committed result afterwards.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic wr_lo);
    logic [W-1:0] eh, el, hi0, lo0;
    int busy_cnt, done_cnt, n;
    model(op, a, b, eh, el);
    hi0 = Hi;
    lo0 = Lo;
    StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b; WriteLoE = wr_lo;
    tick();
    StartE = 1'b0; WriteLoE = 1'b0;
    busy_cnt = 0; done_cnt = 0; n = 0;
    while (BusyE && n < 100) begin
      busy_cnt++;
      if (DoneE) done_cnt++;
      if (n == 5) begin
        check({tag, " hold_hi"}, Hi, hi0);
        check({tag, " hold_lo"}, Lo, lo0);
      end
      tick();
      n++;
    end
    check({tag, " busy_cycles"}, busy_cnt, W + 1);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " hi"}, Hi, eh);
    check({tag, " lo"}, Lo, el);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b0; StartE = 1'b0; OpE = 2'b00; SrcAE = '0; SrcBE = '0;
    WriteHiE = 1'b0; WriteLoE = 1'b0; UseHiLoD = 1'b0;
    #12;
    check("rst hi", Hi, 0);
    check("rst lo", Lo, 0);
    check("rst busy", BusyE, 0);
    check("rst done", DoneE, 0);
    reset = 1'b1;
    tick();

    // Directed cases with literal expectations
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max hi_lit", Hi, 32'hFFFF_FFFE);
    check("multu_max lo_lit", Lo, 32'h0000_0001);
    run_op("mult_m3x5", 2'b00, -32'sd3, 32'd5, 1'b0);
    check("mult_m3x5 lo_lit", Lo, 32'hFFFF_FFF1);
    run_op("div_m7d2", 2'b10, -32'sd7, 32'd2, 1'b0);
    check("div_m7d2 lo_lit", Lo, 32'hFFFF_FFFD);
    check("div_m7d2 hi_lit", Hi, 32'hFFFF_FFFF);
    run_op("divu_by0", 2'b11, 32'h1234, 32'h0, 1'b0);
    check("divu_by0 hi_lit", Hi, 32'h0000_1234);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf lo_lit", Lo, 32'h8000_0000);
    check("div_ovf hi_lit", Hi, 32'h0);
    run_op("div_neg_by0", 2'b10, 32'hFFFF_FF00, 32'h0, 1'b0);

    // Idle: StallMD stays low even with a HI/LO user in Decode
    UseHiLoD = 1'b1;
    #1;
    check("idle stall", StallMD, 0);
    UseHiLoD = 1'b0;

    // Stall window and mthi ignored while busy
    begin
      logic [W-1:0] hi0;
      int cyc;
      hi0 = Hi;
      StartE = 1'b1; OpE = 2'b10; SrcAE = 32'd100; SrcBE = 32'd7;
      tick();
      StartE = 1'b0;
      cyc = 1;
      while (BusyE && cyc < 100) begin
        if (cyc >= 3) begin
          UseHiLoD = 1'b1;
          #1;
          check("stall busy", StallMD, 1);
          check("stall hold_hi", Hi, hi0);
        end
        if (cyc == 5) begin
          WriteHiE = 1'b1; SrcAE = 32'hAAAA;
        end
        tick();
        WriteHiE = 1'b0;
        cyc++;
      end
      check("stall after", StallMD, 0);
      check("stall cycles", cyc, W + 2);
      check("stall rem", Hi, 32'd2);
      check("stall quo", Lo, 32'd14);
      UseHiLoD = 1'b0;
    end

    // Idle mthi + mtlo in the same cycle
    WriteHiE = 1'b1; WriteLoE = 1'b1; SrcAE = 32'h11;
    tick();
    WriteHiE = 1'b0;
    SrcAE = 32'h22;
    tick();
    WriteLoE = 1'b0;
    check("mthi", Hi, 32'h11);
    check("mtlo", Lo, 32'h22);
    WriteHiE = 1'b1; WriteLoE = 1'b0; SrcAE = 32'h33;
    tick();
    WriteHiE = 1'b0;
    check("mthi only hi", Hi, 32'h33);
    check("mthi only lo", Lo, 32'h22);

    // Start wins over a simultaneous mtlo
    run_op("start_mtlo", 2'b01, 32'd9, 32'd11, 1'b1);

    // Reset mid-calculation
    StartE = 1'b1; OpE = 2'b00; SrcAE = 32'd123; SrcBE = 32'd456;
    tick();
    StartE = 1'b0;
    repeat (9) tick();
    check("pre_rst busy", BusyE, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst busy", BusyE, 0);
    check("mid_rst hi", Hi, 0);
    check("mid_rst lo", Lo, 0);
    tick();
    reset = 1'b1;
    tick();
    run_op("multu_7x6", 2'b01, 32'd7, 32'd6, 1'b0);
    check("multu_7x6 lo_lit", Lo, 32'd42);

    // Randomized back-to-back operations
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   op;
      logic [W-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        4: begin a = 32'($urandom_range(0, 255)); b = -32'($urandom_range(1, 9)); end
        default: ;
      endcase
      run_op($sformatf("rand%0d op%0d", i, op), op, a, b, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
